branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch resolution and prediction unit for the CPU pipeline. Decodes the conditional-branch opcodes against the ALU flags, produces a registered taken/not-taken select for the PC mux, and keeps a table of 2-bit saturating predictors indexed by PC. It checks each resolved branch against the prediction it was fetched with, raises a one-cycle mispredict/flush pulse on disagreement, and keeps saturating branch and mispredict statistics counters. It sits between the execute-stage ALU flags and the fetch-stage PC select logic.

## Interface
- PC_W, 16, PC width in bits
- IDX_W, 4, predictor index width; the table has 2**IDX_W entries, indexed by pc[IDX_W-1:0]
- CNT_W, 16, width of each statistics counter
- clk  in  1  system clock; all state is on the rising edge
- rst_n  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- pred_pc  in  PC_W  fetch-stage PC used for the predictor lookup
- pred_taken  out  1  combinational prediction: MSB of entry pred_pc[IDX_W-1:0]
- res_valid  in  1  execute stage presents an instruction to resolve this cycle
- res_opcode  in  5  opcode of the resolving instruction
- res_flags  in  2  ALU flags: [1] = equal/zero, [0] = less-than
- res_pc  in  PC_W  PC of the resolving instruction
- res_pred_taken  in  1  prediction that was made for this instruction at fetch
- stat_clr  in  1  synchronous clear of both statistics counters
- pc_branch_sel_out  out  1  registered; 1 = the resolved branch was taken
- mispredict  out  1  registered one-cycle pulse; actual outcome differs from res_pred_taken
- flush  out  1  registered one-cycle pulse, identical to mispredict
- stat_branches  out  CNT_W  count of resolved branch opcodes, saturating
- stat_mispredicts  out  CNT_W  count of mispredicts, saturating

## Operation
- Branch opcodes: BEQ=5'b10011, BLT=5'b10100, BGT=5'b10101, BNE=5'b10110. All other opcodes are non-branches.
- Taken conditions:
  - BEQ: flags[1]=1
  - BNE: flags[1]=0
  - BLT: flags[0]=1
  - BGT: flags[1]=0 and flags[0]=0 (strictly greater)
- A resolve event is res_valid=1 with a branch opcode. On a resolve event:
  - pc_branch_sel_out <= actual taken.
  - mispredict and flush <= (actual != res_pred_taken).
  - stat_branches increments, saturating at all-ones.
  - stat_mispredicts increments on mispredict, saturating at all-ones.
  - Predictor entry res_pc[IDX_W-1:0] updates: taken increments it, saturating at 2'b11; not-taken decrements it, saturating at 2'b00.
- If res_valid=0, or the opcode is not a branch: pc_branch_sel_out, mispredict and flush are 0 the next cycle. No table or statistics update happens.
- Predictor states: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Prediction = entry[1]. The read path has no bypass: a lookup at the same index as a same-cycle update returns the pre-update value.
- stat_clr has priority over a same-cycle increment; the counters read 0 the next cycle. The predictor table is unaffected by stat_clr.
- Upper PC bits are ignored (aliasing is permitted).

## Timing
- Reset values: pc_branch_sel_out=0, mispredict=0, flush=0, stat_branches=0, stat_mispredicts=0. Every predictor entry resets to 2'b01, so pred_taken=0 after reset.
- Resolve-to-output latency is 1 cycle. The table update is visible to pred_taken 1 cycle after the resolve edge.
- Back-to-back resolves, one per cycle, are supported, including repeated resolves to the same index. Each resolve sees the previous update.
- mispredict/flush are high for exactly one cycle per mispredicting resolve. Consecutive mispredicts give a continuous high level.
- Reset asserted mid-operation clears all outputs and the table immediately, without a clock. No resolve is recorded for a cycle in which rst_n is low.

## Test plan
- Reset, then sweep pred_pc over all 16 indices -> pred_taken=0 everywhere; all outputs 0; both counters 0.
- BEQ with flags=2'b10, res_pred_taken=0, res_pc=0x0005 -> next cycle pc_branch_sel_out=1, mispredict=1, flush=1, stat_branches=1, stat_mispredicts=1, and pred_pc=0x0015 gives pred_taken=1 (aliased, entry 01→10).
- Four taken BLT resolves at index 3, then five not-taken -> entry goes 01→10→11→11→11, then 10→01→00→00→00; the saturation holds at both ends.
- BGT with flags=2'b10 -> not taken. BNE with flags=2'b00 -> taken. Opcode 5'b00001 with res_valid=1 -> all outputs 0 and counters unchanged.
- CNT_W=4: 20 mispredicting resolves -> both counters hold 4'hF. Then stat_clr together with a resolve -> both counters 0.
- rst_n pulsed low between two clock edges during a stream of resolves -> outputs drop to 0 asynchronously and every entry returns to 01.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution and 2-bit predictor table: decodes conditional branches
// against ALU flags, flags mispredicts and keeps saturating statistics.
module branch_resolve_unit #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [4:0]       res_opcode,
  input  logic [1:0]       res_flags,
  input  logic [PC_W-1:0]  res_pc,
  input  logic             res_pred_taken,
  input  logic             stat_clr,
  output logic             pc_branch_sel_out,
  output logic             mispredict,
  output logic             flush,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int unsigned ENTRIES   = 1 << IDX_W;
  localparam logic [4:0]  OP_BEQ    = 5'b10011;
  localparam logic [4:0]  OP_BLT    = 5'b10100;
  localparam logic [4:0]  OP_BGT    = 5'b10101;
  localparam logic [4:0]  OP_BNE    = 5'b10110;
  localparam logic [1:0]  CTR_RESET = 2'b01;

  logic [1:0]       pred_tab [ENTRIES];
  logic             is_branch;
  logic             taken;
  logic             resolve;
  logic             miss;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       entry_next;
  logic             unused_pc;

  // Upper PC bits alias onto the same entries.
  assign unused_pc = ^{pred_pc[PC_W-1:IDX_W], res_pc[PC_W-1:IDX_W]};

  // Opcode decode against flags: [1] = equal, [0] = less-than.
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    case (res_opcode)
      OP_BEQ: begin is_branch = 1'b1; taken = res_flags[1];                   end
      OP_BNE: begin is_branch = 1'b1; taken = ~res_flags[1];                  end
      OP_BLT: begin is_branch = 1'b1; taken = res_flags[0];                   end
      OP_BGT: begin is_branch = 1'b1; taken = ~res_flags[1] & ~res_flags[0]; end
      default: ;
    endcase
  end

  assign resolve = res_valid & is_branch;
  assign miss    = resolve & (taken ^ res_pred_taken);
  assign res_idx = res_pc[IDX_W-1:0];

  // Saturating 2-bit counter step for the resolving entry.
  always_comb begin
    entry_next = pred_tab[res_idx];
    if (taken && (pred_tab[res_idx] != 2'b11)) begin
      entry_next = pred_tab[res_idx] + 2'(1);
    end else if (!taken && (pred_tab[res_idx] != 2'b00)) begin
      entry_next = pred_tab[res_idx] - 2'(1);
    end
  end

  // Lookup reads the stored value; no same-cycle bypass from the update.
  assign pred_taken = pred_tab[pred_pc[IDX_W-1:0]][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_branch_sel_out <= 1'b0;
      mispredict        <= 1'b0;
      flush             <= 1'b0;
    end else begin
      pc_branch_sel_out <= resolve & taken;
      mispredict        <= miss;
      flush             <= miss;
    end
  end

  // Statistics: clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && !(&stat_branches)) begin
        stat_branches <= stat_branches + CNT_W'(1);
      end
      if (miss && !(&stat_mispredicts)) begin
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        pred_tab[i] <= CTR_RESET;
      end
    end else if (resolve) begin
      pred_tab[res_idx] <= entry_next;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus scoreboard
// model of outputs, statistics and the predictor table.
module tb_branch_resolve_unit;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;
  localparam logic [4:0] BNE = 5'b10110;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic             res_valid;
  logic [4:0]       res_opcode;
  logic [1:0]       res_flags;
  logic [PC_W-1:0]  res_pc;
  logic             res_pred_taken;
  logic             stat_clr;
  logic             pc_branch_sel_out;
  logic             mispredict;
  logic             flush;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  branch_resolve_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pred_pc           (pred_pc),
    .pred_taken        (pred_taken),
    .res_valid         (res_valid),
    .res_opcode        (res_opcode),
    .res_flags         (res_flags),
    .res_pc            (res_pc),
    .res_pred_taken    (res_pred_taken),
    .stat_clr          (stat_clr),
    .pc_branch_sel_out (pc_branch_sel_out),
    .mispredict        (mispredict),
    .flush             (flush),
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             sel;
    logic             mis;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] mp;
  } exp_t;

  typedef struct {
    logic        v;
    logic [4:0]  op;
    logic [1:0]  fl;
    logic [15:0] pc;
    logic        pt;
    logic        exp_sel;
    logic        exp_mis;
  } vec_t;

  exp_t             exp_q[$];
  vec_t             vecs[13];
  logic [1:0]       m_tab[16];
  logic [CNT_W-1:0] m_br;
  logic [CNT_W-1:0] m_mp;
  int               checks   = 0;
  int               failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic m_is_br(input logic [4:0] op);
    return (op == BEQ) || (op == BLT) || (op == BGT) || (op == BNE);
  endfunction

  function automatic logic m_taken(input logic [4:0] op, input logic [1:0] fl);
    if (op == BEQ) return fl[1];
    if (op == BNE) return !fl[1];
    if (op == BLT) return fl[0];
    if (op == BGT) return (fl == 2'b00);
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tab[i] = 2'b01;
    m_br = '0;
    m_mp = '0;
  endtask

  task automatic zero_inputs();
    res_valid = 1'b0; res_opcode = 5'd0; res_flags = 2'b00;
    res_pc = '0; res_pred_taken = 1'b0; stat_clr = 1'b0;
  endtask

  // One resolve cycle: drive, check pre-update lookup, push expectation, compare after edge.
  task automatic step(input string name, input logic v, input logic [4:0] op,
                      input logic [1:0] fl, input logic [15:0] pc, input logic pt,
                      input logic clr);
    exp_t e;
    logic tk, rs;
    res_valid = v; res_opcode = op; res_flags = fl; res_pc = pc;
    res_pred_taken = pt; stat_clr = clr;
    #1;
    chk({name, ".lookup"}, 32'(pred_taken), 32'(m_tab[pred_pc[3:0]][1]));
    tk = m_taken(op, fl);
    rs = v && m_is_br(op);
    e.sel = rs && tk;
    e.mis = rs && (tk != pt);
    if (clr) begin
      m_br = '0;
      m_mp = '0;
    end else begin
      if (rs && m_br != '1) m_br = m_br + 1'b1;
      if (e.mis && m_mp != '1) m_mp = m_mp + 1'b1;
    end
    if (rs) begin
      if (tk && m_tab[pc[3:0]] != 2'b11) m_tab[pc[3:0]] = m_tab[pc[3:0]] + 2'b01;
      else if (!tk && m_tab[pc[3:0]] != 2'b00) m_tab[pc[3:0]] = m_tab[pc[3:0]] - 2'b01;
    end
    e.br = m_br;
    e.mp = m_mp;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({name, ".sel"}, 32'(pc_branch_sel_out), 32'(e.sel));
    chk({name, ".mis"}, 32'(mispredict), 32'(e.mis));
    chk({name, ".flush"}, 32'(flush), 32'(e.mis));
    chk({name, ".br"}, 32'(stat_branches), 32'(e.br));
    chk({name, ".mp"}, 32'(stat_mispredicts), 32'(e.mp));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, ".sel0"}, 32'(pc_branch_sel_out), 32'd0);
    chk({name, ".mis0"}, 32'(mispredict), 32'd0);
    chk({name, ".flush0"}, 32'(flush), 32'd0);
    chk({name, ".br0"}, 32'(stat_branches), 32'd0);
    chk({name, ".mp0"}, 32'(stat_mispredicts), 32'd0);
  endtask

  task automatic sweep_pred_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      pred_pc = 16'(i);
      #1;
      chk(name, 32'(pred_taken), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_pred [10];
    vecs[0]  = '{1'b1, BEQ,      2'b10, 16'h0005, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, BEQ,      2'b01, 16'h0021, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, BLT,      2'b01, 16'h0022, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, BLT,      2'b10, 16'h0023, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, BGT,      2'b10, 16'h0024, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, BGT,      2'b00, 16'h0025, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, BGT,      2'b01, 16'h0026, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, BNE,      2'b00, 16'h0027, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, BNE,      2'b10, 16'h0028, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'b00001, 2'b10, 16'h0029, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, BEQ,      2'b10, 16'h002a, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 5'b10111, 2'b00, 16'h002b, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'b10010, 2'b10, 16'h002c, 1'b1, 1'b0, 1'b0};

    zero_inputs();
    pred_pc = '0;
    rst_n   = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_pred_zero("reset.pred");
    check_all_zero("reset.after");

    // Decode table; vector 0 also exercises PC aliasing.
    for (int i = 0; i < 13; i++) begin
      pred_pc = vecs[i].pc;
      step($sformatf("vec%0d", i), vecs[i].v, vecs[i].op, vecs[i].fl, vecs[i].pc,
           vecs[i].pt, 1'b0);
      chk($sformatf("vec%0d.tsel", i), 32'(pc_branch_sel_out), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d.tmis", i), 32'(mispredict), 32'(vecs[i].exp_mis));
      if (i == 0) begin
        pred_pc = 16'h0015;
        #1;
        chk("alias.pred", 32'(pred_taken), 32'd1);
        chk("alias.br", 32'(stat_branches), 32'd1);
        chk("alias.mp", 32'(stat_mispredicts), 32'd1);
      end
    end

    // Saturation at both ends of entry 3; the final taken step exposes 00 vs wrap.
    do_reset();
    pred_pc = 16'h0003;
    exp_pred = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      step($sformatf("sat%0d", k), 1'b1, BLT, (k < 4 || k == 9) ? 2'b01 : 2'b00,
           16'h0003, 1'b0, 1'b0);
      chk($sformatf("sat%0d.pred", k), 32'(pred_taken), 32'(exp_pred[k]));
    end

    // Statistics saturation and clear priority.
    do_reset();
    for (int j = 0; j < 20; j++) begin
      step($sformatf("cnt%0d", j), 1'b1, BEQ, 2'b10, 16'h0040 + 16'(j), 1'b0, 1'b0);
    end
    chk("cnt.br_sat", 32'(stat_branches), 32'hF);
    chk("cnt.mp_sat", 32'(stat_mispredicts), 32'hF);
    step("clr", 1'b1, BEQ, 2'b10, 16'h0001, 1'b0, 1'b1);
    chk("clr.br", 32'(stat_branches), 32'd0);
    chk("clr.mp", 32'(stat_mispredicts), 32'd0);
    step("post_clr", 1'b1, BEQ, 2'b10, 16'h0001, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a resolve stream.
    pred_pc = 16'h0009;
    for (int j = 0; j < 3; j++) begin
      step($sformatf("train%0d", j), 1'b1, BEQ, 2'b10, 16'h0009, 1'b1, 1'b0);
    end
    step("pre_rst", 1'b1, BEQ, 2'b10, 16'h0009, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    zero_inputs();
    sweep_pred_zero("arst.pred");
    check_all_zero("arst.after");
    step("arst.idle", 1'b0, BEQ, 2'b10, 16'h0009, 1'b0, 1'b0);
    pred_pc = 16'h0009;
    step("arst.taken", 1'b1, BEQ, 2'b10, 16'h0009, 1'b0, 1'b0);
    chk("arst.entry9", 32'(pred_taken), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
